// File: rtl/audioport_pkg.sv
// Shared types and constants for the APB protocol monitor.
package audioport_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mon_state_t;

    localparam int APB_MON_ERR_W = 8;

    localparam int APB_E_PEN_NOSEL    = 0;
    localparam int APB_E_NO_SETUP     = 1;
    localparam int APB_E_NO_ENABLE    = 2;
    localparam int APB_E_SETUP_ABORT  = 3;
    localparam int APB_E_UNSTABLE     = 4;
    localparam int APB_E_ACCESS_ABORT = 5;
    localparam int APB_E_TIMEOUT      = 6;
    localparam int APB_E_MISALIGN     = 7;

endpackage

// File: rtl/apb_mon_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module apb_mon_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d, base;

    always_comb begin
        base    = clr_i ? '0 : count_q;
        count_d = base;
        if (inc_i && (base != '1)) begin
            count_d = base + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB3 protocol monitor: sticky violation bits, saturating counters,
// first-violation address capture and a maskable interrupt.
//
// state  | meaning
// IDLE   | no transfer in progress; the observed cycle is judged as a bus idle/setup
// SETUP  | a setup cycle was seen; the observed cycle must be the first access cycle
// ACCESS | inside an access phase waiting for PREADY
module apb_protocol_monitor
    import audioport_pkg::*;
#(
    parameter int         AW             = 32,
    parameter int         DW             = 32,
    parameter int         CNT_W          = 16,
    parameter int         TIMEOUT_CYCLES = 16,
    parameter logic [7:0] ERR_MASK       = 8'hFF,
    parameter bit         CHECK_ALIGN    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     psel_in,
    input  logic                     penable_in,
    input  logic                     pwrite_in,
    input  logic [AW-1:0]            paddr_in,
    input  logic [DW-1:0]            pwdata_in,
    input  logic                     pready_in,
    input  logic                     pslverr_in,
    input  logic                     clr_in,
    output logic [APB_MON_ERR_W-1:0] err_out,
    output logic                     irq_out,
    output logic [CNT_W-1:0]         xfer_count_out,
    output logic [CNT_W-1:0]         slverr_count_out,
    output logic [CNT_W-1:0]         viol_count_out,
    output logic [AW-1:0]            last_err_addr_out
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

    apb_mon_state_t            state_q, state_d;
    logic [AW-1:0]             addr_cap_q, addr_cap_d;
    logic                      write_cap_q, write_cap_d;
    logic [DW-1:0]             wdata_cap_q, wdata_cap_d;
    logic [WAIT_W-1:0]         wait_q, wait_d, wait_inc;
    logic [APB_MON_ERR_W-1:0]  err_q, err_d, err_new;
    logic [AW-1:0]             last_addr_q, last_addr_d;
    logic                      irq_q;
    logic                      inc_xfer, inc_slv, viol;
    logic                      do_idle, quiet, fields_changed;

    assign fields_changed = (paddr_in != addr_cap_q) || (pwrite_in != write_cap_q) ||
                            (write_cap_q && (pwdata_in != wdata_cap_q));
    assign wait_inc = wait_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        addr_cap_d  = addr_cap_q;
        write_cap_d = write_cap_q;
        wdata_cap_d = wdata_cap_q;
        wait_d      = wait_q;
        err_new     = '0;
        inc_xfer    = 1'b0;
        inc_slv     = 1'b0;
        do_idle     = 1'b0;
        quiet       = 1'b0;

        case (state_q)
            IDLE: begin
                do_idle = 1'b1;
            end
            SETUP: begin
                if (!psel_in) begin
                    err_new[APB_E_SETUP_ABORT] = 1'b1;
                    state_d = IDLE;
                end else if (!penable_in) begin
                    err_new[APB_E_NO_ENABLE] = 1'b1;
                    do_idle = 1'b1;
                    quiet   = 1'b1;
                end else begin
                    err_new[APB_E_UNSTABLE] = fields_changed;
                    addr_cap_d  = paddr_in;
                    write_cap_d = pwrite_in;
                    wdata_cap_d = pwdata_in;
                    wait_d      = '0;
                    if (pready_in) begin
                        inc_xfer = 1'b1;
                        inc_slv  = pslverr_in;
                        state_d  = IDLE;
                    end else begin
                        state_d  = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!psel_in || !penable_in) begin
                    err_new[APB_E_ACCESS_ABORT] = 1'b1;
                    do_idle = 1'b1;
                    quiet   = 1'b1;
                end else begin
                    // Re-capturing each cycle reports a field change once, not every cycle after it.
                    err_new[APB_E_UNSTABLE] = fields_changed;
                    addr_cap_d  = paddr_in;
                    write_cap_d = pwrite_in;
                    wdata_cap_d = pwdata_in;
                    if (pready_in) begin
                        inc_xfer = 1'b1;
                        inc_slv  = pslverr_in;
                        state_d  = IDLE;
                    end else if ((TIMEOUT_CYCLES != 0) && (wait_q != WAIT_LIMIT)) begin
                        wait_d = wait_inc;
                        err_new[APB_E_TIMEOUT] = (wait_inc == WAIT_LIMIT);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Resync evaluates the same cycle as a fresh idle cycle without new errors.
        if (do_idle) begin
            state_d = IDLE;
            if (!psel_in && penable_in) begin
                err_new[APB_E_PEN_NOSEL] = !quiet;
            end else if (psel_in && penable_in) begin
                err_new[APB_E_NO_SETUP] = !quiet;
            end else if (psel_in && !penable_in) begin
                state_d     = SETUP;
                addr_cap_d  = paddr_in;
                write_cap_d = pwrite_in;
                wdata_cap_d = pwdata_in;
                if (CHECK_ALIGN && (paddr_in[1:0] != 2'b00) && !quiet) begin
                    err_new[APB_E_MISALIGN] = 1'b1;
                end
            end
        end
    end

    assign viol  = |err_new;
    assign err_d = (clr_in ? '0 : err_q) | err_new;

    always_comb begin
        last_addr_d = clr_in ? '0 : last_addr_q;
        if (viol && (clr_in || (err_q == '0))) begin
            last_addr_d = paddr_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_cap_q  <= '0;
            write_cap_q <= 1'b0;
            wdata_cap_q <= '0;
            wait_q      <= '0;
            err_q       <= '0;
            last_addr_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cap_q  <= addr_cap_d;
            write_cap_q <= write_cap_d;
            wdata_cap_q <= wdata_cap_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            last_addr_q <= last_addr_d;
            irq_q       <= |(err_q & ERR_MASK);
        end
    end

    apb_mon_sat_counter #(.W(CNT_W)) u_xfer_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr_in),
        .inc_i   (inc_xfer),
        .count_o (xfer_count_out)
    );

    apb_mon_sat_counter #(.W(CNT_W)) u_slverr_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr_in),
        .inc_i   (inc_slv),
        .count_o (slverr_count_out)
    );

    apb_mon_sat_counter #(.W(CNT_W)) u_viol_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr_in),
        .inc_i   (viol),
        .count_o (viol_count_out)
    );

    assign err_out           = err_q;
    assign irq_out           = irq_q;
    assign last_err_addr_out = last_addr_q;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Directed stimulus for apb_protocol_monitor; expectations are queued and
// checked by an independent monitor process.
module tb_apb_protocol_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel_in = 1'b0, penable_in = 1'b0, pwrite_in = 1'b0;
    logic [31:0] paddr_in = '0, pwdata_in = '0;
    logic        pready_in = 1'b0, pslverr_in = 1'b0, clr_in = 1'b0;
    logic [7:0]  err_out;
    logic        irq_out;
    logic [15:0] xfer_count_out, slverr_count_out, viol_count_out;
    logic [31:0] last_err_addr_out;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;
    event chk_ev;

    typedef struct {
        string       name;
        int          due;
        logic [7:0]  err;
        logic        irq;
        logic [15:0] xfer;
        logic [15:0] slv;
        logic [15:0] viol;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];

    apb_protocol_monitor #(
        .AW(32), .DW(32), .CNT_W(16), .TIMEOUT_CYCLES(16),
        .ERR_MASK(8'hFF), .CHECK_ALIGN(1'b1)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .psel_in           (psel_in),
        .penable_in        (penable_in),
        .pwrite_in         (pwrite_in),
        .paddr_in          (paddr_in),
        .pwdata_in         (pwdata_in),
        .pready_in         (pready_in),
        .pslverr_in        (pslverr_in),
        .clr_in            (clr_in),
        .err_out           (err_out),
        .irq_out           (irq_out),
        .xfer_count_out    (xfer_count_out),
        .slverr_count_out  (slverr_count_out),
        .viol_count_out    (viol_count_out),
        .last_err_addr_out (last_err_addr_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input string nm, input int dly, input logic [7:0] e, input logic irq,
                        input int x, input int s, input int v, input logic [31:0] a);
        exp_t t;
        t.name = nm;
        t.due  = cyc + dly;
        t.err  = e;
        t.irq  = irq;
        t.xfer = 16'(x);
        t.slv  = 16'(s);
        t.viol = 16'(v);
        t.addr = a;
        exp_q.push_back(t);
    endtask

    task automatic drive(input logic ps, input logic pe, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy, input logic se, input logic cl);
        psel_in    = ps;
        penable_in = pe;
        pwrite_in  = wr;
        paddr_in   = a;
        pwdata_in  = d;
        pready_in  = rdy;
        pslverr_in = se;
        clr_in     = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [31:0] a, input logic wr, input logic [31:0] d, input logic cl = 1'b0);
        drive(1'b1, 1'b0, wr, a, d, 1'b0, 1'b0, cl);
    endtask

    task automatic acc(input logic [31:0] a, input logic wr, input logic [31:0] d,
                       input logic rdy, input logic se = 1'b0);
        drive(1'b1, 1'b1, wr, a, d, rdy, se, 1'b0);
    endtask

    task automatic idle(input logic pe = 1'b0, input logic cl = 1'b0);
        drive(1'b0, pe, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, cl);
    endtask

    // Monitor: compares every queued expectation once its due cycle is reached.
    initial begin
        exp_t t;
        forever begin
            @(negedge clk or chk_ev);
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                t = exp_q.pop_front();
                n_assert++;
                if ({err_out, irq_out, xfer_count_out, slverr_count_out, viol_count_out, last_err_addr_out} !==
                    {t.err, t.irq, t.xfer, t.slv, t.viol, t.addr}) begin
                    n_fail++;
                    $display("FAIL %s: got err=%h irq=%b xfer=%0d slv=%0d viol=%0d addr=%h, want err=%h irq=%b xfer=%0d slv=%0d viol=%0d addr=%h",
                             t.name, err_out, irq_out, xfer_count_out, slverr_count_out, viol_count_out,
                             last_err_addr_out, t.err, t.irq, t.xfer, t.slv, t.viol, t.addr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, want < 100000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        push("reset", 0, 8'h00, 1'b0, 0, 0, 0, 32'h0);
        ->chk_ev;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean write with two wait states
        setup(32'h8, 1'b1, 32'hA5);
        acc(32'h8, 1'b1, 32'hA5, 1'b0);
        acc(32'h8, 1'b1, 32'hA5, 1'b0);
        push("clean_write", 1, 8'h00, 1'b0, 1, 0, 0, 32'h0);
        acc(32'h8, 1'b1, 32'hA5, 1'b1);
        idle();

        // Write with PSLVERR, then back-to-back read (PWDATA free to change on a read)
        setup(32'hC, 1'b1, 32'h11);
        acc(32'hC, 1'b1, 32'h11, 1'b0);
        push("slverr_write", 1, 8'h00, 1'b0, 2, 1, 0, 32'h0);
        acc(32'hC, 1'b1, 32'h11, 1'b1, 1'b1);
        setup(32'h10, 1'b0, 32'h0);
        acc(32'h10, 1'b0, 32'hFF, 1'b0);
        push("b2b_read", 1, 8'h00, 1'b0, 3, 1, 0, 32'h0);
        acc(32'h10, 1'b0, 32'h77, 1'b1);
        idle();

        // PSEL and PENABLE together from idle
        push("no_setup", 1, 8'h02, 1'b0, 3, 1, 1, 32'h40);
        acc(32'h40, 1'b0, 32'h0, 1'b0);
        push("no_setup_irq", 1, 8'h02, 1'b1, 3, 1, 1, 32'h40);
        idle();

        idle(1'b0, 1'b1);
        push("clear", 1, 8'h00, 1'b0, 0, 0, 0, 32'h0);
        idle();

        // 15 ACCESS wait cycles stays under the timeout
        setup(32'h20, 1'b1, 32'h1);
        acc(32'h20, 1'b1, 32'h1, 1'b0);
        for (int i = 0; i < 15; i++) acc(32'h20, 1'b1, 32'h1, 1'b0);
        push("no_timeout", 1, 8'h00, 1'b0, 1, 0, 0, 32'h0);
        acc(32'h20, 1'b1, 32'h1, 1'b1);
        idle();

        // Address change during ACCESS, then timeout on the 16th ACCESS wait
        setup(32'h10, 1'b1, 32'h33);
        acc(32'h10, 1'b1, 32'h33, 1'b0);
        push("unstable_addr", 1, 8'h10, 1'b0, 1, 0, 1, 32'h14);
        acc(32'h14, 1'b1, 32'h33, 1'b0);
        for (int i = 0; i < 13; i++) acc(32'h14, 1'b1, 32'h33, 1'b0);
        push("pre_timeout", 1, 8'h10, 1'b1, 1, 0, 1, 32'h14);
        acc(32'h14, 1'b1, 32'h33, 1'b0);
        push("timeout", 1, 8'h50, 1'b1, 1, 0, 2, 32'h14);
        acc(32'h14, 1'b1, 32'h33, 1'b0);
        for (int i = 0; i < 3; i++) acc(32'h14, 1'b1, 32'h33, 1'b0);
        push("timeout_once", 1, 8'h50, 1'b1, 2, 0, 2, 32'h14);
        acc(32'h14, 1'b1, 32'h33, 1'b1);
        idle();

        // Clear coinciding with a misaligned setup
        push("clr_misalign", 1, 8'h80, 1'b1, 0, 0, 1, 32'h2);
        setup(32'h2, 1'b1, 32'h0, 1'b1);
        push("after_clr_xfer", 1, 8'h80, 1'b1, 1, 0, 1, 32'h2);
        acc(32'h2, 1'b1, 32'h0, 1'b1);
        idle();

        push("pen_nosel", 1, 8'h81, 1'b1, 1, 0, 2, 32'h2);
        idle(1'b1);

        setup(32'h30, 1'b1, 32'h0);
        push("setup_abort", 1, 8'h89, 1'b1, 1, 0, 3, 32'h2);
        idle();

        setup(32'h34, 1'b1, 32'h0);
        push("no_enable", 1, 8'h8D, 1'b1, 1, 0, 4, 32'h2);
        setup(32'h38, 1'b1, 32'h0);
        push("resync_xfer", 1, 8'h8D, 1'b1, 2, 0, 4, 32'h2);
        acc(32'h38, 1'b1, 32'h0, 1'b1);
        idle();

        setup(32'h44, 1'b0, 32'h0);
        acc(32'h44, 1'b0, 32'h0, 1'b0);
        acc(32'h44, 1'b0, 32'h0, 1'b0);
        push("access_abort", 1, 8'hAD, 1'b1, 2, 0, 5, 32'h2);
        idle();

        setup(32'h48, 1'b1, 32'h1);
        push("unstable_wdata", 1, 8'hBD, 1'b1, 3, 0, 6, 32'h2);
        acc(32'h48, 1'b1, 32'h2, 1'b1);
        idle();

        // Reset pulsed while in ACCESS with PSEL/PENABLE held
        setup(32'h50, 1'b1, 32'h0);
        acc(32'h50, 1'b1, 32'h0, 1'b0);
        acc(32'h50, 1'b1, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        push("async_reset", 0, 8'h00, 1'b0, 0, 0, 0, 32'h0);
        ->chk_ev;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push("post_reset", 1, 8'h02, 1'b0, 0, 0, 1, 32'h50);
        @(posedge clk);
        #1;
        push("post_reset_irq", 1, 8'h02, 1'b1, 0, 0, 1, 32'h50);
        idle();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL drain: got %0d pending checks, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
